// File: rtl/divider.sv
// Iterative restoring divider (DIV/DIVU): one quotient bit per clock, then sign fix-up.
// Optional macro DIVIDER_DZ_EN adds the dz port and a one-cycle zero-divisor completion.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
`ifdef DIVIDER_DZ_EN
  ,
  output logic             dz
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_next;

  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dsr;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;
  logic               neg_r;
  logic               load;
  logic               last_iter;
  logic               zero_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   rem_lo;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
`ifdef DIVIDER_DZ_EN
  logic               dz_pend;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = zero_div ? FIX : CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    load      = (state == IDLE) && start;
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  // The trial difference is WIDTH+1 bits wide, so its top bit is the restore decision.
  always_comb begin
    a_mag   = (sign && a[WIDTH-1]) ? -a : a;
    b_mag   = (sign && b[WIDTH-1]) ? -b : b;
    rem_lo  = rem[WIDTH-1:0];
    shifted = {rem_lo, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dsr};
`ifdef DIVIDER_DZ_EN
    zero_div = (b == '0);
`else
    zero_div = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem   <= '0;
      quo   <= '0;
      dsr   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q     <= '0;
      r     <= '0;
      done  <= 1'b0;
`ifdef DIVIDER_DZ_EN
      dz      <= 1'b0;
      dz_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DIVIDER_DZ_EN
      dz   <= 1'b0;
`endif
      if (load) begin
        dsr <= b_mag;
        cnt <= '0;
        // A zero divisor preloads the final answer so FIX needs no special case.
        if (zero_div) begin
          quo   <= '1;
          rem   <= {1'b0, a};
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          quo   <= a_mag;
          rem   <= '0;
          neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r <= sign & a[WIDTH-1];
        end
`ifdef DIVIDER_DZ_EN
        dz_pend <= zero_div;
`endif
      end else if (state == CALC) begin
        if (!diff[WIDTH]) begin
          rem <= diff;
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= shifted;
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
        cnt <= cnt + 1'b1;
      end else if (state == FIX) begin
        q    <= neg_q ? -quo : quo;
        r    <= neg_r ? -rem_lo : rem_lo;
        done <= 1'b1;
`ifdef DIVIDER_DZ_EN
        dz   <= dz_pend;
`endif
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: randomized DIV/DIVU against an arithmetic reference model.
// Builds with or without DIVIDER_DZ_EN.
module tb_divider;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          sign = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  q;
  logic [W-1:0]  r;
  logic          busy;
  logic          done;
`ifdef DIVIDER_DZ_EN
  logic          dz;
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sign  (sign),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done)
`ifdef DIVIDER_DZ_EN
    ,
    .dz    (dz)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    bit           chk;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: language-level truncating division on 64-bit values.
  function automatic exp_t model(input bit s, input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t   e;
    longint sa, sbv, qq, rr;
    e.dz  = 1'b0;
    e.chk = 1'b1;
    e.due = 0;
    if (bb == 0) begin
      e.q   = '1;
      e.r   = aa;
      e.dz  = DZ_EN;
      e.chk = DZ_EN;
    end else if (s) begin
      sa  = longint'($signed(aa));
      sbv = longint'($signed(bb));
      qq  = sa / sbv;
      rr  = sa % sbv;
      e.q = qq[W-1:0];
      e.r = rr[W-1:0];
    end else begin
      e.q = aa / bb;
      e.r = aa % bb;
    end
    return e;
  endfunction

  // Issues a start that the DUT must accept; pushes the expectation once edge N is known.
  task automatic applyStimulus(input bit s, input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t e;
    e = model(s, aa, bb);
    start = 1'b1;
    sign  = s;
    a     = aa;
    b     = bb;
    @(posedge clk);
    #1;
    e.due = cyc + ((DZ_EN && bb == 0) ? 1 : W + 1);
    sb.push_back(e);
    start = 1'b0;
    sign  = ~s;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL done_timeout: %0d results still pending after %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  // Monitor: every done pops one expectation; a done with nothing pending is an error.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("latency", W'(cyc), W'(e.due));
        checkOutput("busy_at_done", W'(busy), W'(0));
        if (e.chk) begin
          checkOutput("quotient", q, e.q);
          checkOutput("remainder", r, e.r);
        end
`ifdef DIVIDER_DZ_EN
        checkOutput("dz", W'(dz), W'(e.dz));
`endif
      end
    end
  end

  initial begin
    int busy_cnt;
    bit s;
    logic [W-1:0] ra, rb;

    #1;
    checkOutput("reset_q", q, '0);
    checkOutput("reset_r", r, '0);
    checkOutput("reset_busy", W'(busy), W'(0));
    checkOutput("reset_done", W'(done), W'(0));
`ifdef DIVIDER_DZ_EN
    checkOutput("reset_dz", W'(dz), W'(0));
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] unsigned 100/7 with busy window");
    applyStimulus(1'b0, 32'h64, 32'h7);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
    end
    checkOutput("busy_cycles", W'(busy_cnt), W'(W + 1));
    waitIdle(50);

    $display("[TB] signed directed cases");
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'h2);
    waitIdle(50);
    applyStimulus(1'b1, 32'h7, 32'hFFFF_FFFE);
    waitIdle(50);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(50);
    applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(50);

    $display("[TB] start while busy, then back-to-back start at done");
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; sign = 1'b0; a = 32'd9; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) break;
    end
    applyStimulus(1'b0, 32'd9, 32'd3);
    waitIdle(50);
    repeat (40) @(negedge clk);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 32'hFFFF_FF00, 32'h7);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_q", q, '0);
    checkOutput("abort_r", r, '0);
    checkOutput("abort_busy", W'(busy), W'(0));
    checkOutput("abort_done", W'(done), W'(0));
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(1'b0, 32'd1000, 32'd33);
    waitIdle(50);

`ifdef DIVIDER_DZ_EN
    $display("[TB] zero divisor fast path");
    applyStimulus(1'b0, 32'h1234_5678, 32'h0);
    waitIdle(10);
    applyStimulus(1'b1, 32'h1234_5678, 32'h0);
    waitIdle(10);
    applyStimulus(1'b0, 32'd50, 32'd5);
    waitIdle(50);
`endif

    $display("[TB] randomized operands");
    for (int n = 0; n < 150; n++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       ra = 32'h8000_0000;
        1:       ra = '1;
        2:       ra = W'($urandom_range(0, 255));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = 32'h8000_0000;
        3:       rb = W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      applyStimulus(s, ra, rb);
      waitIdle(50);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
